// File: rtl/tlcd_bus_scheduler_if.sv
// Requester and LCD-side signal bundle for the text-LCD bus scheduler.
// Handshake: a requester raises REQn_VALID with REQn_RS/REQn_DATA and holds all three
// until it sees REQn_READY, a one-cycle pulse in the cycle after its byte was captured.
interface tlcd_bus_scheduler_if;
    logic       REQ0_VALID;
    logic       REQ0_RS;
    logic [7:0] REQ0_DATA;
    logic       REQ0_READY;
    logic       REQ1_VALID;
    logic       REQ1_RS;
    logic [7:0] REQ1_DATA;
    logic       REQ1_READY;
    logic       TLCD_E;
    logic       TLCD_RS;
    logic       TLCD_RW;
    logic [7:0] TLCD_DATA;
    logic       INIT_DONE;
    logic       BUSY;

    modport master (
        output REQ0_VALID, REQ0_RS, REQ0_DATA, REQ1_VALID, REQ1_RS, REQ1_DATA,
        input  REQ0_READY, REQ1_READY, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA,
        input  INIT_DONE, BUSY
    );

    modport slave (
        input  REQ0_VALID, REQ0_RS, REQ0_DATA, REQ1_VALID, REQ1_RS, REQ1_DATA,
        output REQ0_READY, REQ1_READY, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA,
        output INIT_DONE, BUSY
    );
endinterface

// File: rtl/tlcd_bus_scheduler.sv
// Two-requester round-robin scheduler for an HD44780-style text LCD write bus,
// running the power-on init sequence itself and pacing strobes by command hold time.
module tlcd_bus_scheduler #(
    parameter int E_PULSE_WIDTH = 1,
    parameter int EXEC_TIME     = 40,
    parameter int CLEAR_TIME    = 1640,
    parameter int INIT_DELAY    = 15000
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    tlcd_bus_scheduler_if.slave  bus,
    output logic [2:0]           dbg_state_o
);

    localparam int MAX_A = (INIT_DELAY > CLEAR_TIME) ? INIT_DELAY : CLEAR_TIME;
    localparam int MAX_T = (MAX_A > EXEC_TIME) ? MAX_A : EXEC_TIME;
    localparam int CNT_W = $clog2(MAX_T + 1);

    // Each wait leaves one cycle for the INIT_ISSUE/IDLE state that launches the next strobe,
    // so the next E rise lands exactly hold cycles after the previous one.
    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(INIT_DELAY - 2);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_TIME - 2);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TIME - 2);

    typedef enum logic [2:0] {
        POWER_WAIT = 3'd0,
        INIT_ISSUE = 3'd1,
        PULSE      = 3'd2,
        EXEC       = 3'd3,
        IDLE       = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             rdy0_q, rdy0_d;
    logic             rdy1_q, rdy1_d;
    logic             done_q, done_d;
    logic             gnt1;
    logic [CNT_W-1:0] hold_last;
    logic [7:0]       init_byte;

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state_q <= POWER_WAIT;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            last_q  <= 1'b1;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        init_byte = 8'h38;
        case (idx_q)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        last_d    = last_q;
        e_d       = e_q;
        rs_d      = rs_q;
        data_d    = data_q;
        rdy0_d    = 1'b0;
        rdy1_d    = 1'b0;
        done_d    = done_q;
        gnt1      = 1'b0;
        // Hold time follows the byte currently on the bus; clear/home are the slow ones.
        hold_last = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ? CLEAR_LAST : EXEC_LAST;

        case (state_q)
            POWER_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = INIT_ISSUE;
                    idx_d   = 2'd0;
                end
            end
            INIT_ISSUE: begin
                rs_d    = 1'b0;
                data_d  = init_byte;
                e_d     = 1'b1;
                cnt_d   = '0;
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == E_LAST) begin
                    e_d     = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == hold_last) begin
                    if (!done_q && idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = INIT_ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                // INIT_DONE rises on the first IDLE edge, the same edge that may accept a request.
                done_d = 1'b1;
                cnt_d  = '0;
                if (bus.REQ0_VALID || bus.REQ1_VALID) begin
                    gnt1    = bus.REQ1_VALID && (!bus.REQ0_VALID || !last_q);
                    last_d  = gnt1;
                    rs_d    = gnt1 ? bus.REQ1_RS : bus.REQ0_RS;
                    data_d  = gnt1 ? bus.REQ1_DATA : bus.REQ0_DATA;
                    rdy0_d  = !gnt1;
                    rdy1_d  = gnt1;
                    e_d     = 1'b1;
                    state_d = PULSE;
                end
            end
            default: begin
                state_d = POWER_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.TLCD_E     = e_q;
    assign bus.TLCD_RS    = rs_q;
    assign bus.TLCD_RW    = 1'b0;
    assign bus.TLCD_DATA  = data_q;
    assign bus.REQ0_READY = rdy0_q;
    assign bus.REQ1_READY = rdy1_q;
    assign bus.INIT_DONE  = done_q;
    assign bus.BUSY       = (state_q != IDLE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_tlcd_bus_scheduler.sv
// Directed-sequence bench for tlcd_bus_scheduler: init timing, single requester, clear
// pacing, round-robin contention, asynchronous reset mid-strobe and pre-init gating.
`timescale 1ns/1ps
module tb_tlcd_bus_scheduler;

    localparam int E_W        = 1;
    localparam int EXEC_T     = 40;
    localparam int CLEAR_T    = 1640;
    localparam int INIT_DELAY = 15000;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic [2:0] dbg_state;

    tlcd_bus_scheduler_if bus();

    tlcd_bus_scheduler #(
        .E_PULSE_WIDTH(E_W), .EXEC_TIME(EXEC_T), .CLEAR_TIME(CLEAR_T), .INIT_DELAY(INIT_DELAY)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .bus(bus), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #500 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #(64'd95_000 * 64'd1000);
        $display("FAIL watchdog: observed no finish, required finish before 95000 cycles");
        $fatal(1, "watchdog");
    end

    typedef struct { int cyc; logic rs; logic [7:0] data; } strobe_t;
    typedef struct { int cyc; int who; } rdy_t;

    strobe_t    str_q[$];
    rdy_t       rdy_q[$];
    int         wid_q[$];
    logic [9:0] exp_q[$];   // {who, rs, data} in expected grant order

    int   n_checks = 0;
    int   n_errors = 0;
    logic e_prev = 1'b0;
    logic d_prev = 1'b0;
    int   e_rise = 0;
    int   idone_cyc = -1;
    int   last_gnt = 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int hold_of(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? CLEAR_T : EXEC_T;
    endfunction

    // monitor: records strobes, pulse widths, READY pulses and the INIT_DONE rise
    always @(posedge CLK) begin
        #1;
        if (bus.TLCD_E && !e_prev) begin
            str_q.push_back('{cyc, bus.TLCD_RS, bus.TLCD_DATA});
            e_rise = cyc;
        end
        if (!bus.TLCD_E && e_prev) wid_q.push_back(cyc - e_rise);
        e_prev = bus.TLCD_E;
        if (bus.INIT_DONE && !d_prev) idone_cyc = cyc;
        d_prev = bus.INIT_DONE;
        if (bus.REQ0_READY || bus.REQ1_READY) begin
            chk("single_ready", bus.REQ0_READY & bus.REQ1_READY, 0);
            rdy_q.push_back('{cyc, bus.REQ1_READY ? 1 : 0});
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic get_strobe(output strobe_t s, input int budget);
        int n = 0;
        while (str_q.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("strobe_arrived", str_q.size() > 0, 1);
        if (str_q.size() > 0) s = str_q.pop_front();
        else s = '{-1, 1'b0, 8'h00};
    endtask

    task automatic release_reset(output int base);
        @(negedge CLK);
        str_q.delete();
        rdy_q.delete();
        wid_q.delete();
        idone_cyc = -1;
        RESETN = 1'b0;
        base = cyc;
    endtask

    // init model: fixed byte list, first strobe INIT_DELAY after release, each gap = hold of previous
    task automatic check_init(input int base);
        logic [7:0] seq [4];
        strobe_t s;
        int t;
        int n;
        seq = '{8'h38, 8'h0C, 8'h06, 8'h01};
        t = base + INIT_DELAY;
        for (int i = 0; i < 4; i++) begin
            get_strobe(s, (i == 0) ? INIT_DELAY + 100 : 200);
            chk("init_time", s.cyc, t);
            chk("init_rs", s.rs, 0);
            chk("init_data", s.data, seq[i]);
            t = t + hold_of(1'b0, seq[i]);
        end
        n = 0;
        while (idone_cyc < 0 && n < CLEAR_T + 100) begin
            tick();
            n++;
        end
        chk("init_done_time", idone_cyc, t);
    endtask

    // scoreboard: pops strobes/READYs/widths and compares with exp_q, gaps from hold rule
    task automatic check_stream(input int n);
        strobe_t    s;
        rdy_t       r;
        logic [9:0] e;
        int         prev_cyc = 0;
        int         prev_hold = 0;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            get_strobe(s, 10);
            chk("xfer_rs", s.rs, e[8]);
            chk("xfer_data", s.data, e[7:0]);
            if (i > 0) chk("xfer_spacing", s.cyc - prev_cyc, prev_hold);
            chk("ready_present", rdy_q.size() > 0, 1);
            if (rdy_q.size() > 0) begin
                r = rdy_q.pop_front();
                chk("ready_who", r.who, e[9]);
                chk("ready_cycle", r.cyc, s.cyc);
            end
            chk("e_width_present", wid_q.size() > 0, 1);
            if (wid_q.size() > 0) chk("e_width", wid_q.pop_front(), E_W);
            prev_cyc = s.cyc;
            prev_hold = hold_of(e[8], e[7:0]);
        end
        chk("no_extra_strobe", str_q.size(), 0);
        chk("no_extra_ready", rdy_q.size(), 0);
    endtask

    task automatic wait_ready(input int who, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(who == 0 ? bus.REQ0_READY : bus.REQ1_READY) && n < CLEAR_T + 100);
        chk(tag, (who == 0) ? bus.REQ0_READY : bus.REQ1_READY, 1);
    endtask

    initial begin
        int         base;
        logic [8:0] item;
        logic [8:0] q0 [4];
        logic [8:0] q1 [4];
        int         i0, i1, got, n, w;
        logic [7:0] held;
        strobe_t    s;
        rdy_t       r;

        bus.REQ0_VALID = 1'b0; bus.REQ0_RS = 1'b0; bus.REQ0_DATA = 8'h00;
        bus.REQ1_VALID = 1'b0; bus.REQ1_RS = 1'b0; bus.REQ1_DATA = 8'h00;

        // reset values
        ticks(3);
        chk("rst_e", bus.TLCD_E, 0);
        chk("rst_rs", bus.TLCD_RS, 0);
        chk("rst_rw", bus.TLCD_RW, 0);
        chk("rst_data", bus.TLCD_DATA, 0);
        chk("rst_ready0", bus.REQ0_READY, 0);
        chk("rst_ready1", bus.REQ1_READY, 0);
        chk("rst_init_done", bus.INIT_DONE, 0);
        chk("rst_busy", bus.BUSY, 1);

        // power-on init with no requests
        release_reset(base);
        check_init(base);
        chk("init_no_ready", rdy_q.size(), 0);
        chk("idle_busy", bus.BUSY, 0);

        // single requester: one command then 40 random data bytes
        for (int i = 0; i < 41; i++) begin
            item = (i == 0) ? {1'b0, 8'h40} : {1'b1, 8'($urandom_range(0, 255))};
            exp_q.push_back({1'b0, item});
            bus.REQ0_VALID = 1'b1;
            {bus.REQ0_RS, bus.REQ0_DATA} = item;
            wait_ready(0, "req0_handshake");
        end
        bus.REQ0_VALID = 1'b0;
        last_gnt = 0;
        ticks(60);
        check_stream(41);

        // clear timing from requester 1, with a short-lived request 0 that must go unserved
        exp_q.push_back({1'b1, 1'b0, 8'h01});
        exp_q.push_back({1'b1, 1'b1, 8'h01});
        exp_q.push_back({1'b1, 1'b1, 8'($urandom_range(0, 255))});
        bus.REQ1_VALID = 1'b1;
        {bus.REQ1_RS, bus.REQ1_DATA} = exp_q[0][8:0];
        wait_ready(1, "req1_clear_handshake");
        {bus.REQ1_RS, bus.REQ1_DATA} = exp_q[1][8:0];
        ticks(100);
        bus.REQ0_VALID = 1'b1;
        bus.REQ0_RS = 1'b1;
        bus.REQ0_DATA = 8'($urandom_range(0, 255));
        ticks(5);
        bus.REQ0_VALID = 1'b0;
        wait_ready(1, "req1_ctrl_handshake");
        {bus.REQ1_RS, bus.REQ1_DATA} = exp_q[2][8:0];
        wait_ready(1, "req1_tail_handshake");
        bus.REQ1_VALID = 1'b0;
        last_gnt = 1;
        ticks(60);
        check_stream(3);

        // contention: both requesters always valid; model alternates away from the last grant
        for (int i = 0; i < 4; i++) begin
            q0[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
            q1[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
        end
        i0 = 0;
        i1 = 0;
        for (int g = 0; g < 8; g++) begin
            w = 1 - last_gnt;
            if (w == 0) begin exp_q.push_back({1'b0, q0[i0]}); i0++; end
            else begin exp_q.push_back({1'b1, q1[i1]}); i1++; end
            last_gnt = w;
        end
        i0 = 0;
        i1 = 0;
        got = 0;
        n = 0;
        bus.REQ0_VALID = 1'b1; {bus.REQ0_RS, bus.REQ0_DATA} = q0[0];
        bus.REQ1_VALID = 1'b1; {bus.REQ1_RS, bus.REQ1_DATA} = q1[0];
        while (got < 8 && n < 8 * (CLEAR_T + 60)) begin
            tick();
            n++;
            if (bus.REQ0_READY) begin
                got++; i0++;
                if (i0 < 4) {bus.REQ0_RS, bus.REQ0_DATA} = q0[i0];
                else bus.REQ0_VALID = 1'b0;
            end
            if (bus.REQ1_READY) begin
                got++; i1++;
                if (i1 < 4) {bus.REQ1_RS, bus.REQ1_DATA} = q1[i1];
                else bus.REQ1_VALID = 1'b0;
            end
        end
        chk("contention_grants", got, 8);
        bus.REQ0_VALID = 1'b0;
        bus.REQ1_VALID = 1'b0;
        ticks(60);
        check_stream(8);

        // reset while E is high, then pre-init gating with request 0 held throughout
        held = 8'($urandom_range(0, 255));
        bus.REQ0_VALID = 1'b1;
        bus.REQ0_RS = 1'b1;
        bus.REQ0_DATA = held;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.TLCD_E && n < 100);
        chk("pulse_seen", bus.TLCD_E, 1);
        RESETN = 1'b1;
        #1;
        chk("async_rst_e", bus.TLCD_E, 0);
        chk("async_rst_init_done", bus.INIT_DONE, 0);
        chk("async_rst_ready0", bus.REQ0_READY, 0);
        chk("async_rst_busy", bus.BUSY, 1);
        ticks(4);
        release_reset(base);
        check_init(base);
        chk("gate_ready_count", rdy_q.size(), 1);
        if (rdy_q.size() > 0) begin
            r = rdy_q.pop_front();
            chk("gate_ready_who", r.who, 0);
            chk("gate_ready_cycle", r.cyc, idone_cyc);
        end
        bus.REQ0_VALID = 1'b0;
        get_strobe(s, 10);
        chk("gate_accept_cycle", s.cyc, idone_cyc);
        chk("gate_accept_data", s.data, held);
        chk("gate_accept_rs", s.rs, 1);
        ticks(60);
        chk("gate_no_extra_strobe", str_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
